// File: rtl/hazard3_apb_async_bridge_tmo_pkg.sv
// Shared definitions for the hazard3 APB clock-domain-crossing bridge.
// Holds the src-side handshake FSM encoding and the helpers that size the
// request bundle {paddr, pwdata, pwrite, pstrb, pprot} and the response
// bundle {prdata, pslverr}.
package hazard3_apb_async_bridge_tmo_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,  // no request in flight
    StReq  = 2'd1,  // req high, waiting for ack high
    StRel  = 2'd2   // req low, waiting for ack low
  } src_state_e;

  // W_REQ = W_ADDR + W_DATA + W_DATA/8 + 3 + 1
  function automatic int unsigned req_width(int unsigned w_addr, int unsigned w_data);
    return w_addr + w_data + w_data / 8 + 3 + 1;
  endfunction

  // Response bundle: prdata plus pslverr.
  function automatic int unsigned rsp_width(int unsigned w_data);
    return w_data + 1;
  endfunction

endpackage

// File: rtl/hazard3_sync_1bit.sv
// Single-bit synchroniser: a chain of N_STAGES flops in the receiving clock
// domain, cleared by that domain's asynchronous active-low reset.
// Ports: clk/rst_n (receiving domain), d (asynchronous input), q (synchronised).
module hazard3_sync_1bit #(
  parameter int unsigned N_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* keep = "true" *) logic [N_STAGES-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[N_STAGES-2:0], d};
    end
  end

  assign q = stages[N_STAGES-1];

endmodule

// File: rtl/hazard3_apb_async_bridge_tmo.sv
// APB4 clock-domain-crossing bridge: DTM side (src, APB completer) to Debug
// Module side (dst, APB requester) over a 4-phase req/ack handshake.
// Optional src-side timeout: define HAZARD3_APB_ASYNC_TIMEOUT_EN to add the
// timeout counter, abort flag, stall logic and src_orphan; otherwise src_orphan
// is tied low and transfers wait indefinitely.
// Ports:
//   clk_src/rst_n_src : src clock, async active-low reset
//   clk_dst/rst_n_dst : dst clock, async active-low reset
//   src_*             : APB completer (psel/penable/pwrite/paddr/pwdata/pstrb/pprot
//                       in; prdata/pready/pslverr out), src_orphan out
//   dst_*             : APB requester (psel/penable/pwrite/paddr/pwdata/pstrb/pprot
//                       out; prdata/pready/pslverr in)
module hazard3_apb_async_bridge_tmo
  import hazard3_apb_async_bridge_tmo_pkg::*;
#(
  parameter int unsigned W_ADDR         = 8,
  parameter int unsigned W_DATA         = 32,
  parameter int unsigned N_SYNC_STAGES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk_src,
  input  logic                rst_n_src,
  input  logic                clk_dst,
  input  logic                rst_n_dst,

  input  logic                src_psel,
  input  logic                src_penable,
  input  logic                src_pwrite,
  input  logic [W_ADDR-1:0]   src_paddr,
  input  logic [W_DATA-1:0]   src_pwdata,
  input  logic [W_DATA/8-1:0] src_pstrb,
  input  logic [2:0]          src_pprot,
  output logic [W_DATA-1:0]   src_prdata,
  output logic                src_pready,
  output logic                src_pslverr,
  output logic                src_orphan,

  output logic                dst_psel,
  output logic                dst_penable,
  output logic                dst_pwrite,
  output logic [W_ADDR-1:0]   dst_paddr,
  output logic [W_DATA-1:0]   dst_pwdata,
  output logic [W_DATA/8-1:0] dst_pstrb,
  output logic [2:0]          dst_pprot,
  input  logic [W_DATA-1:0]   dst_prdata,
  input  logic                dst_pready,
  input  logic                dst_pslverr
);

  localparam int unsigned W_REQ = req_width(W_ADDR, W_DATA);
  localparam int unsigned W_RSP = rsp_width(W_DATA);

  if (N_SYNC_STAGES < 2) begin : g_chk_sync
    $error("N_SYNC_STAGES must be at least 2");
  end
  if (W_DATA % 8 != 0) begin : g_chk_data
    $error("W_DATA must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 4) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be at least 4");
  end

  // ---------------------------------------------------------------- src side
  src_state_e                     state;
  (* keep = "true" *) logic       req;
  logic                           ack_sync;
  logic                           pready_r;
  logic                           pslverr_r;
  logic [W_DATA-1:0]              prdata_r;
  logic                           pending;  // access accepted but not yet launched
  logic                           abort;
  (* keep = "true" *) logic [W_REQ-1:0] req_bundle;
  (* keep = "true" *) logic [W_RSP-1:0] rsp_bundle;

  logic setup, access_wait, launch, real_done, timeout_fire;

  assign setup       = src_psel && !src_penable;
  assign access_wait = src_psel && src_penable && !pready_r;
  assign real_done   = (state == StRel) && !ack_sync && !abort;
  // Launch needs ack low too, so a stale ack left over from a src reset is
  // never mistaken for the acknowledgement of a new request.
  assign launch      = (setup || (access_wait && pending)) && (state == StIdle) && !ack_sync &&
                       !timeout_fire;

`ifdef HAZARD3_APB_ASYNC_TIMEOUT_EN
  localparam int unsigned W_CNT = $clog2(TIMEOUT_CYCLES);
  logic [W_CNT-1:0] tmo_cnt;
  // Fires at the end of access cycle TIMEOUT_CYCLES-1 so the registered
  // error pready is visible in access cycle TIMEOUT_CYCLES.
  assign timeout_fire = access_wait && (tmo_cnt == W_CNT'(TIMEOUT_CYCLES - 2));
`else
  assign timeout_fire = 1'b0;
  assign abort        = 1'b0;
`endif

  always_ff @(posedge clk_src or negedge rst_n_src) begin
    if (!rst_n_src) begin
      state     <= StIdle;
      req       <= 1'b0;
      pready_r  <= 1'b1;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
      pending   <= 1'b0;
`ifdef HAZARD3_APB_ASYNC_TIMEOUT_EN
      abort     <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      if (setup) begin
        pready_r <= 1'b0;
        pending  <= !launch;
      end else if (access_wait && launch) begin
        pending  <= 1'b0;
      end

      case (state)
        StIdle: begin
          if (launch) begin
            state <= StReq;
            req   <= 1'b1;
          end
        end
        StReq: begin
          if (ack_sync) begin
            state <= StRel;
            req   <= 1'b0;
          end
        end
        StRel: begin
          if (!ack_sync) begin
            state <= StIdle;
            if (!abort) begin
              pready_r  <= 1'b1;
              pslverr_r <= rsp_bundle[0];
              prdata_r  <= rsp_bundle[W_RSP-1:1];
            end
`ifdef HAZARD3_APB_ASYNC_TIMEOUT_EN
            else begin
              abort <= 1'b0;  // orphaned response is dropped
            end
`endif
          end
        end
        default: begin
          state <= StIdle;
          req   <= 1'b0;
        end
      endcase

`ifdef HAZARD3_APB_ASYNC_TIMEOUT_EN
      if (setup) begin
        tmo_cnt <= '0;
      end else if (timeout_fire && !real_done) begin
        pready_r  <= 1'b1;
        pslverr_r <= 1'b1;
        prdata_r  <= '0;
        pending   <= 1'b0;
        // Launched request keeps handshaking; its response is discarded.
        if (!pending) abort <= 1'b1;
      end else if (access_wait) begin
        tmo_cnt <= tmo_cnt + W_CNT'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk_src) begin
    if (launch) req_bundle <= {src_paddr, src_pwdata, src_pwrite, src_pstrb, src_pprot};
  end

  assign src_pready  = pready_r;
  assign src_pslverr = pslverr_r;
  assign src_prdata  = prdata_r;
  assign src_orphan  = abort;

  // ---------------------------------------------------------------- dst side
  (* keep = "true" *) logic       ack;
  logic                           req_sync;
  logic                           psel_r;
  logic                           penable_r;
  (* keep = "true" *) logic [W_REQ-1:0] dst_bundle;

  hazard3_sync_1bit #(.N_STAGES(N_SYNC_STAGES)) u_sync_req (
    .clk   (clk_dst),
    .rst_n (rst_n_dst),
    .d     (req),
    .q     (req_sync)
  );

  hazard3_sync_1bit #(.N_STAGES(N_SYNC_STAGES)) u_sync_ack (
    .clk   (clk_src),
    .rst_n (rst_n_src),
    .d     (ack),
    .q     (ack_sync)
  );

  always_ff @(posedge clk_dst or negedge rst_n_dst) begin
    if (!rst_n_dst) begin
      ack       <= 1'b0;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
    end else begin
      if (req_sync && !ack) begin
        ack    <= 1'b1;
        psel_r <= 1'b1;
      end else if (!req_sync && ack && !psel_r) begin
        ack    <= 1'b0;
      end
      if (psel_r && !penable_r) begin
        penable_r <= 1'b1;
      end else if (penable_r && dst_pready) begin
        psel_r    <= 1'b0;
        penable_r <= 1'b0;
      end
    end
  end

  // Direct cross-domain captures: the source registers are held stable for
  // the whole synchroniser delay of the handshake that qualifies them.
  always_ff @(posedge clk_dst) begin
    if (req_sync && !ack)        dst_bundle <= req_bundle;
    if (penable_r && dst_pready) rsp_bundle <= {dst_prdata, dst_pslverr};
  end

  assign dst_psel    = psel_r;
  assign dst_penable = penable_r;
  assign {dst_paddr, dst_pwdata, dst_pwrite, dst_pstrb, dst_pprot} = dst_bundle;

endmodule

// File: tb/tb_hazard3_apb_async_bridge_tmo.sv
// Self-checking bench for hazard3_apb_async_bridge_tmo: directed and random
// APB transfers through a dst completer model, src reset mid-transfer, and
// (when HAZARD3_APB_ASYNC_TIMEOUT_EN is defined) timeout/orphan scenarios.
module tb_hazard3_apb_async_bridge_tmo;

  localparam int unsigned W_ADDR = 8;
  localparam int unsigned W_DATA = 32;
  localparam int unsigned TMO    = 16;

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] wdata;
    logic              write;
    logic [3:0]        strb;
    logic [2:0]        prot;
  } xfer_t;

  logic clk_src, rst_n_src, clk_dst, rst_n_dst;
  logic src_psel, src_penable, src_pwrite;
  logic [W_ADDR-1:0] src_paddr;
  logic [W_DATA-1:0] src_pwdata, src_prdata;
  logic [3:0] src_pstrb;
  logic [2:0] src_pprot;
  logic src_pready, src_pslverr, src_orphan;
  logic dst_psel, dst_penable, dst_pwrite;
  logic [W_ADDR-1:0] dst_paddr;
  logic [W_DATA-1:0] dst_pwdata, dst_prdata;
  logic [3:0] dst_pstrb;
  logic [2:0] dst_pprot;
  logic dst_pready, dst_pslverr;

  int checks = 0;
  int errors = 0;

  // Transfers observed on the dst APB port, in order.
  xfer_t seen[$];
  logic [W_DATA-1:0] rsp_data;
  logic rsp_err;
  int rsp_delay;

  hazard3_apb_async_bridge_tmo #(
    .W_ADDR         (W_ADDR),
    .W_DATA         (W_DATA),
    .N_SYNC_STAGES  (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_src     (clk_src),
    .rst_n_src   (rst_n_src),
    .clk_dst     (clk_dst),
    .rst_n_dst   (rst_n_dst),
    .src_psel    (src_psel),
    .src_penable (src_penable),
    .src_pwrite  (src_pwrite),
    .src_paddr   (src_paddr),
    .src_pwdata  (src_pwdata),
    .src_pstrb   (src_pstrb),
    .src_pprot   (src_pprot),
    .src_prdata  (src_prdata),
    .src_pready  (src_pready),
    .src_pslverr (src_pslverr),
    .src_orphan  (src_orphan),
    .dst_psel    (dst_psel),
    .dst_penable (dst_penable),
    .dst_pwrite  (dst_pwrite),
    .dst_paddr   (dst_paddr),
    .dst_pwdata  (dst_pwdata),
    .dst_pstrb   (dst_pstrb),
    .dst_pprot   (dst_pprot),
    .dst_prdata  (dst_prdata),
    .dst_pready  (dst_pready),
    .dst_pslverr (dst_pslverr)
  );

  // 3:1 clock ratio, dst the faster side.
  initial clk_src = 1'b0;
  always #15 clk_src = ~clk_src;
  initial clk_dst = 1'b0;
  always #5 clk_dst = ~clk_dst;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // dst completer: waits rsp_delay access cycles, then answers and logs.
  initial begin
    int wait_cnt;
    wait_cnt    = 0;
    dst_pready  = 1'b0;
    dst_prdata  = '0;
    dst_pslverr = 1'b0;
    forever begin
      @(negedge clk_dst);
      if (dst_psel && dst_penable && !dst_pready) begin
        if (wait_cnt >= rsp_delay) begin
          dst_pready  = 1'b1;
          dst_prdata  = rsp_data;
          dst_pslverr = rsp_err;
          seen.push_back('{dst_paddr, dst_pwdata, dst_pwrite, dst_pstrb, dst_pprot});
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        dst_pready = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t x;
    x.addr  = W_ADDR'($urandom);
    x.wdata = $urandom;
    x.write = 1'($urandom);
    x.strb  = 4'($urandom);
    x.prot  = 3'($urandom);
    return x;
  endfunction

  // One APB transfer; cycles counts access cycles (first = 1) up to pready.
  task automatic apb_xfer(input xfer_t x, input int budget, output logic [W_DATA-1:0] rdata,
                          output logic err, output int cycles, output logic done);
    rdata = '0;
    err   = 1'b0;
    done  = 1'b0;
    @(posedge clk_src); #1;
    src_psel    = 1'b1;
    src_penable = 1'b0;
    src_paddr   = x.addr;
    src_pwdata  = x.wdata;
    src_pwrite  = x.write;
    src_pstrb   = x.strb;
    src_pprot   = x.prot;
    @(posedge clk_src); #1;
    src_penable = 1'b1;
    cycles = 0;
    while (!done && cycles < budget) begin
      cycles++;
      if (src_pready) begin
        done  = 1'b1;
        rdata = src_prdata;
        err   = src_pslverr;
      end else begin
        @(posedge clk_src); #1;
      end
    end
    @(posedge clk_src); #1;
    src_psel    = 1'b0;
    src_penable = 1'b0;
  endtask

  // Normal transfer: dst must see x exactly once and src must return the reply.
  task automatic normal_xfer(input string tag, input xfer_t x, input logic [W_DATA-1:0] d,
                             input logic e, input int delay);
    logic [W_DATA-1:0] rdata;
    logic err, done;
    int cycles, base;
    rsp_data  = d;
    rsp_err   = e;
    rsp_delay = delay;
    base = seen.size();
    apb_xfer(x, 200, rdata, err, cycles, done);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_prdata"}, 64'(rdata), 64'(d));
    check({tag, "_pslverr"}, 64'(err), 64'(e));
    check({tag, "_dst_count"}, 64'(seen.size()), 64'(base + 1));
    if (seen.size() > base) check({tag, "_dst_fields"}, 64'(seen[base]), 64'(x));
  endtask

  initial begin
    xfer_t x, xb, xc;
    logic [W_DATA-1:0] rdata;
    logic err, done;
    int cycles, base, n, glitch;

    src_psel = 1'b0; src_penable = 1'b0; src_pwrite = 1'b0;
    src_paddr = '0; src_pwdata = '0; src_pstrb = '0; src_pprot = '0;
    rsp_data = '0; rsp_err = 1'b0; rsp_delay = 0;
    rst_n_src = 1'b0;
    rst_n_dst = 1'b0;
    repeat (3) @(posedge clk_src);
    #1;
    check("rst_pready", 64'(src_pready), 64'd1);
    check("rst_pslverr", 64'(src_pslverr), 64'd0);
    check("rst_prdata", 64'(src_prdata), 64'd0);
    check("rst_orphan", 64'(src_orphan), 64'd0);
    check("rst_dst_psel", 64'(dst_psel), 64'd0);
    check("rst_dst_penable", 64'(dst_penable), 64'd0);
    rst_n_src = 1'b1;
    rst_n_dst = 1'b1;
    repeat (4) @(posedge clk_src);

    // Directed write, then directed read with error and slow dst.
    x = '{8'h10, 32'hDEADBEEF, 1'b1, 4'hF, 3'b010};
    normal_xfer("wr", x, 32'h0, 1'b0, 0);
    x = '{8'h24, 32'h0, 1'b0, 4'h0, 3'b001};
    normal_xfer("rd", x, 32'h12345678, 1'b1, 5);

    for (int i = 0; i < 12; i++) begin
      normal_xfer($sformatf("rnd%0d", i), rand_xfer(), $urandom, 1'($urandom),
                  int'($urandom_range(0, 6)));
    end
    check("orphan_idle", 64'(src_orphan), 64'd0);

    // src reset while dst is mid-transfer: dst completes once, no replay.
    x = rand_xfer();
    rsp_delay = 3;
    base = seen.size();
    @(posedge clk_src); #1;
    src_psel = 1'b1; src_penable = 1'b0;
    src_paddr = x.addr; src_pwdata = x.wdata; src_pwrite = x.write;
    src_pstrb = x.strb; src_pprot = x.prot;
    @(posedge clk_src); #1;
    src_penable = 1'b1;
    n = 0;
    while (!dst_psel && n < 50) begin
      @(posedge clk_src); #1;
      n++;
    end
    check("srst_dst_started", 64'(n < 50), 64'd1);
    rst_n_src = 1'b0;
    @(posedge clk_src); #1;
    check("srst_pready", 64'(src_pready), 64'd1);
    src_psel = 1'b0; src_penable = 1'b0;
    @(posedge clk_src); #1;
    rst_n_src = 1'b1;
    repeat (40) @(posedge clk_src);
    #1;
    check("srst_dst_count", 64'(seen.size()), 64'(base + 1));
    if (seen.size() > base) check("srst_dst_fields", 64'(seen[base]), 64'(x));
    check("srst_dst_idle", 64'(dst_psel), 64'd0);
    normal_xfer("after_srst", rand_xfer(), $urandom, 1'b0, 1);

`ifdef HAZARD3_APB_ASYNC_TIMEOUT_EN
    // Timeout with dst held in reset, then drain the orphan with src idle.
    rsp_delay = 0;
    x = rand_xfer();
    base = seen.size();
    rst_n_dst = 1'b0;
    apb_xfer(x, 100, rdata, err, cycles, done);
    check("tmo_done", 64'(done), 64'd1);
    check("tmo_cycle", 64'(cycles), 64'(TMO));
    check("tmo_pslverr", 64'(err), 64'd1);
    check("tmo_prdata", 64'(rdata), 64'd0);
    check("tmo_orphan", 64'(src_orphan), 64'd1);
    check("tmo_dst_none", 64'(seen.size()), 64'(base));
    rst_n_dst = 1'b1;
    n = 0;
    glitch = 0;
    while (src_orphan && n < 100) begin
      @(posedge clk_src); #1;
      n++;
      if (src_pready !== 1'b1) glitch++;
    end
    check("drain_orphan", 64'(src_orphan), 64'd0);
    check("drain_pready_pulse", 64'(glitch), 64'd0);
    repeat (10) @(posedge clk_src);
    #1;
    check("drain_replay_count", 64'(seen.size()), 64'(base + 1));
    if (seen.size() > base) check("drain_replay_fields", 64'(seen[base]), 64'(x));

    // Second timeout, then a new access issued while the orphan still drains.
    xb = rand_xfer();
    base = seen.size();
    rst_n_dst = 1'b0;
    apb_xfer(xb, 100, rdata, err, cycles, done);
    check("tmo2_cycle", 64'(cycles), 64'(TMO));
    check("tmo2_pslverr", 64'(err), 64'd1);
    rst_n_dst = 1'b1;
    repeat (4) @(posedge clk_src);
    #1;
    check("stall_orphan_set", 64'(src_orphan), 64'd1);
    xc = rand_xfer();
    rsp_data = $urandom;
    rsp_err  = 1'b0;
    apb_xfer(xc, 100, rdata, err, cycles, done);
    check("stall_done", 64'(done), 64'd1);
    check("stall_pslverr", 64'(err), 64'd0);
    check("stall_prdata", 64'(rdata), 64'(rsp_data));
    check("stall_orphan_clr", 64'(src_orphan), 64'd0);
    check("stall_dst_count", 64'(seen.size()), 64'(base + 2));
    if (seen.size() > base + 1) begin
      check("stall_replay_fields", 64'(seen[base]), 64'(xb));
      check("stall_second_fields", 64'(seen[base+1]), 64'(xc));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
